ec_scalar_mul_ctrl: RTL and testbench

Sequences the shared EC point-op engine (P+Q / 2P over GF(prime), 6-bit operands) to compute R = k·P. It uses MSB-first double-and-add. The block handles the point at infinity and inverse-point cases itself, because the engine cannot represent them. It sits between the top-level request interface and one engine instance, and is the engine's only requester.

---
 rtl/ec_scalar_mul_ctrl_pkg.sv | 18 +
 rtl/ec_scalar_mul_ctrl_if.sv | 55 +++++
 rtl/ec_scalar_mul_ctrl_classify.sv | 37 +++
 rtl/ec_scalar_mul_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_ec_scalar_mul_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ec_scalar_mul_ctrl_pkg.sv
// Shared definitions for the EC scalar-multiply controller: state encoding and default widths.
package ec_pkg;

    localparam int unsigned K_WIDTH_DEF  = 6;
    localparam int unsigned P_WIDTH_DEF  = 6;
    localparam int unsigned WDOG_CYC_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        DBL,
        DWAIT,
        ADD,
        AWAIT,
        NEXT,
        DONE
    } ec_state_e;

endpackage

// File: rtl/ec_scalar_mul_ctrl_if.sv
// Request/result and engine handshake bundle for ec_scalar_mul_ctrl.
// out_err exists only when EC_SM_WDOG_EN is defined.
interface ec_scalar_mul_ctrl_if
    import ec_pkg::*;
#(
    parameter int unsigned K_WIDTH = K_WIDTH_DEF,
    parameter int unsigned P_WIDTH = P_WIDTH_DEF
);
    logic               in_valid;
    logic [K_WIDTH-1:0] in_k;
    logic [P_WIDTH-1:0] in_Px;
    logic [P_WIDTH-1:0] in_Py;
    logic [P_WIDTH-1:0] in_prime;
    logic [P_WIDTH-1:0] in_a;
    logic               busy;
    logic               out_valid;
    logic [P_WIDTH-1:0] out_Rx;
    logic [P_WIDTH-1:0] out_Ry;
    logic               out_inf;
`ifdef EC_SM_WDOG_EN
    logic               out_err;
`endif
    logic               eng_in_valid;
    logic [P_WIDTH-1:0] eng_Px;
    logic [P_WIDTH-1:0] eng_Py;
    logic [P_WIDTH-1:0] eng_Qx;
    logic [P_WIDTH-1:0] eng_Qy;
    logic [P_WIDTH-1:0] eng_prime;
    logic [P_WIDTH-1:0] eng_a;
    logic               eng_out_valid;
    logic [P_WIDTH-1:0] eng_Rx;
    logic [P_WIDTH-1:0] eng_Ry;

    // master: requester plus engine side; slave: the controller
    modport master (
        output in_valid, in_k, in_Px, in_Py, in_prime, in_a,
        output eng_out_valid, eng_Rx, eng_Ry,
        input  busy, out_valid, out_Rx, out_Ry, out_inf,
`ifdef EC_SM_WDOG_EN
        input  out_err,
`endif
        input  eng_in_valid, eng_Px, eng_Py, eng_Qx, eng_Qy, eng_prime, eng_a
    );

    modport slave (
        input  in_valid, in_k, in_Px, in_Py, in_prime, in_a,
        input  eng_out_valid, eng_Rx, eng_Ry,
        output busy, out_valid, out_Rx, out_Ry, out_inf,
`ifdef EC_SM_WDOG_EN
        output out_err,
`endif
        output eng_in_valid, eng_Px, eng_Py, eng_Qx, eng_Qy, eng_prime, eng_a
    );

endinterface

// File: rtl/ec_scalar_mul_ctrl_classify.sv
// Decides, for a doubling or an addition step, whether the engine is needed
// or the result is trivially infinity / the base point.
module ec_pt_classify
    import ec_pkg::*;
#(
    parameter int unsigned P_WIDTH = P_WIDTH_DEF
) (
    input  logic               is_add,
    input  logic               r_inf,
    input  logic [P_WIDTH-1:0] r_x,
    input  logic [P_WIDTH-1:0] r_y,
    input  logic [P_WIDTH-1:0] p_x,
    input  logic [P_WIDTH-1:0] p_y,
    output logic               use_engine,
    output logic               set_inf,
    output logic               load_p
);

    always_comb begin
        use_engine = 1'b0;
        set_inf    = 1'b0;
        load_p     = 1'b0;
        if (!is_add) begin
            if (!r_inf) begin
                if (r_y == '0) set_inf = 1'b1;
                else           use_engine = 1'b1;
            end
        end else begin
            // R == P with Py != 0 is a doubling of P; R == -P collapses to infinity
            if (r_inf)                          load_p     = 1'b1;
            else if (r_x != p_x)                use_engine = 1'b1;
            else if (r_y == p_y && p_y != '0)   use_engine = 1'b1;
            else                                set_inf    = 1'b1;
        end
    end

endmodule

// File: rtl/ec_scalar_mul_ctrl.sv
// MSB-first double-and-add sequencer driving one shared EC point-op engine.
// Optional engine watchdog and out_err port: define EC_SM_WDOG_EN.
module ec_scalar_mul_ctrl
    import ec_pkg::*;
#(
    parameter int unsigned K_WIDTH  = K_WIDTH_DEF,
    parameter int unsigned P_WIDTH  = P_WIDTH_DEF
`ifdef EC_SM_WDOG_EN
   ,parameter int unsigned WDOG_CYC = WDOG_CYC_DEF
`endif
) (
    input logic                 clk,
    input logic                 rst_n,
    ec_scalar_mul_ctrl_if.slave bus
);

    localparam int unsigned I_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

    ec_state_e          state_q, state_d;
    logic [K_WIDTH-1:0] k_q, k_d;
    logic [P_WIDTH-1:0] px_q, px_d, py_q, py_d, prime_q, prime_d, a_q, a_d;
    logic [P_WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
    logic               r_inf_q, r_inf_d;
    logic [I_W-1:0]     i_q, i_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d, out_inf_q, out_inf_d;
    logic [P_WIDTH-1:0] out_rx_q, out_rx_d, out_ry_q, out_ry_d;
    logic               eng_in_valid_q, eng_in_valid_d;
    logic [P_WIDTH-1:0] eng_px_q, eng_px_d, eng_py_q, eng_py_d;
    logic [P_WIDTH-1:0] eng_qx_q, eng_qx_d, eng_qy_q, eng_qy_d;
    logic               cls_use_engine, cls_set_inf, cls_load_p;
`ifdef EC_SM_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               err_q, err_d, out_err_q, out_err_d;
`endif

    ec_pt_classify #(.P_WIDTH(P_WIDTH)) u_classify (
        .is_add     (state_q == ADD),
        .r_inf      (r_inf_q),
        .r_x        (rx_q),
        .r_y        (ry_q),
        .p_x        (px_q),
        .p_y        (py_q),
        .use_engine (cls_use_engine),
        .set_inf    (cls_set_inf),
        .load_p     (cls_load_p)
    );

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        px_d           = px_q;
        py_d           = py_q;
        prime_d        = prime_q;
        a_d            = a_q;
        rx_d           = rx_q;
        ry_d           = ry_q;
        r_inf_d        = r_inf_q;
        i_d            = i_q;
        busy_d         = busy_q;
        out_valid_d    = 1'b0;
        out_rx_d       = '0;
        out_ry_d       = '0;
        out_inf_d      = 1'b0;
        eng_in_valid_d = 1'b0;
        eng_px_d       = eng_px_q;
        eng_py_d       = eng_py_q;
        eng_qx_d       = eng_qx_q;
        eng_qy_d       = eng_qy_q;
`ifdef EC_SM_WDOG_EN
        wdog_d         = wdog_q;
        err_d          = err_q;
        out_err_d      = 1'b0;
`endif
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                k_d     = bus.in_k;
                px_d    = bus.in_Px;
                py_d    = bus.in_Py;
                prime_d = bus.in_prime;
                a_d     = bus.in_a;
                i_d     = I_W'(K_WIDTH - 1);
                r_inf_d = 1'b1;
                busy_d  = 1'b1;
`ifdef EC_SM_WDOG_EN
                err_d   = 1'b0;
`endif
                state_d = DBL;
            end
            DBL, ADD: begin
                if (state_q == ADD && !k_q[i_q]) begin
                    state_d = NEXT;
                end else if (cls_load_p) begin
                    rx_d    = px_q;
                    ry_d    = py_q;
                    r_inf_d = 1'b0;
                    state_d = NEXT;
                end else if (cls_use_engine) begin
                    // operands stay on the bus until the engine answers
                    eng_in_valid_d = 1'b1;
                    eng_px_d       = rx_q;
                    eng_py_d       = ry_q;
                    eng_qx_d       = (state_q == DBL) ? rx_q : px_q;
                    eng_qy_d       = (state_q == DBL) ? ry_q : py_q;
`ifdef EC_SM_WDOG_EN
                    wdog_d         = '0;
`endif
                    state_d        = (state_q == DBL) ? DWAIT : AWAIT;
                end else begin
                    if (cls_set_inf) r_inf_d = 1'b1;
                    state_d = (state_q == DBL) ? ADD : NEXT;
                end
            end
            DWAIT, AWAIT: begin
                if (bus.eng_out_valid) begin
                    rx_d     = bus.eng_Rx;
                    ry_d     = bus.eng_Ry;
                    r_inf_d  = 1'b0;
                    eng_px_d = '0;
                    eng_py_d = '0;
                    eng_qx_d = '0;
                    eng_qy_d = '0;
                    state_d  = (state_q == DWAIT) ? ADD : NEXT;
                end
`ifdef EC_SM_WDOG_EN
                else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
                    err_d    = 1'b1;
                    eng_px_d = '0;
                    eng_py_d = '0;
                    eng_qx_d = '0;
                    eng_qy_d = '0;
                    state_d  = DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            NEXT: begin
                if (i_q == '0) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q - 1'b1;
                    state_d = DBL;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                out_inf_d   = r_inf_q;
                out_rx_d    = r_inf_q ? '0 : rx_q;
                out_ry_d    = r_inf_q ? '0 : ry_q;
`ifdef EC_SM_WDOG_EN
                if (err_q) begin
                    out_inf_d = 1'b0;
                    out_rx_d  = '0;
                    out_ry_d  = '0;
                end
                out_err_d   = err_q;
`endif
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            k_q            <= '0;
            px_q           <= '0;
            py_q           <= '0;
            prime_q        <= '0;
            a_q            <= '0;
            rx_q           <= '0;
            ry_q           <= '0;
            r_inf_q        <= 1'b0;
            i_q            <= '0;
            busy_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_rx_q       <= '0;
            out_ry_q       <= '0;
            out_inf_q      <= 1'b0;
            eng_in_valid_q <= 1'b0;
            eng_px_q       <= '0;
            eng_py_q       <= '0;
            eng_qx_q       <= '0;
            eng_qy_q       <= '0;
`ifdef EC_SM_WDOG_EN
            wdog_q         <= '0;
            err_q          <= 1'b0;
            out_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            px_q           <= px_d;
            py_q           <= py_d;
            prime_q        <= prime_d;
            a_q            <= a_d;
            rx_q           <= rx_d;
            ry_q           <= ry_d;
            r_inf_q        <= r_inf_d;
            i_q            <= i_d;
            busy_q         <= busy_d;
            out_valid_q    <= out_valid_d;
            out_rx_q       <= out_rx_d;
            out_ry_q       <= out_ry_d;
            out_inf_q      <= out_inf_d;
            eng_in_valid_q <= eng_in_valid_d;
            eng_px_q       <= eng_px_d;
            eng_py_q       <= eng_py_d;
            eng_qx_q       <= eng_qx_d;
            eng_qy_q       <= eng_qy_d;
`ifdef EC_SM_WDOG_EN
            wdog_q         <= wdog_d;
            err_q          <= err_d;
            out_err_q      <= out_err_d;
`endif
        end
    end

    assign bus.busy         = busy_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_Rx       = out_rx_q;
    assign bus.out_Ry       = out_ry_q;
    assign bus.out_inf      = out_inf_q;
    assign bus.eng_in_valid = eng_in_valid_q;
    assign bus.eng_Px       = eng_px_q;
    assign bus.eng_Py       = eng_py_q;
    assign bus.eng_Qx       = eng_qx_q;
    assign bus.eng_Qy       = eng_qy_q;
    assign bus.eng_prime    = prime_q;
    assign bus.eng_a        = a_q;
`ifdef EC_SM_WDOG_EN
    assign bus.out_err      = out_err_q;
`endif

endmodule

// File: tb/tb_ec_scalar_mul_ctrl.sv
// Directed bench for ec_scalar_mul_ctrl over y^2 = x^3 + x + 6 mod 11 with a
// behavioural engine of programmable latency; watchdog case under EC_SM_WDOG_EN.
module tb_ec_scalar_mul_ctrl;
    import ec_pkg::*;

    localparam int unsigned KW = 6;
    localparam int unsigned PW = 6;
    localparam int          PR = 11;
    localparam int          CA = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ec_scalar_mul_ctrl_if #(.K_WIDTH(KW), .P_WIDTH(PW)) bus ();

    ec_scalar_mul_ctrl #(.K_WIDTH(KW), .P_WIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // engine model: 0 = correct arithmetic, 1 = doubling returns the inverse point, 2 = never answers
    int      eng_mode = 0;
    int      eng_lat  = 1;
    int      eng_calls = 0;
    int      op_changes = 0;
    int      ov_count = 0;
    logic    pend = 1'b0;
    int      cnt = 0;
    logic [PW-1:0] h_px, h_py, h_qx, h_qy, res_x, res_y;
    logic [PW-1:0] iss_px[4], iss_py[4], iss_qx[4], iss_qy[4], iss_prime[4], iss_a[4];

    function automatic int md(input int v);
        return ((v % PR) + PR) % PR;
    endfunction

    function automatic int minv(input int v);
        for (int t = 1; t < PR; t++) if (md(v * t) == 1) return t;
        return 0;
    endfunction

    function automatic logic [2*PW-1:0] eng_calc(input int x1, y1, x2, y2, input int mode);
        int lam, x3, y3;
        if (x1 == x2 && y1 == y2) begin
            if (mode == 1) return {PW'(x1), PW'(md(-y1))};
            lam = md(md(3 * x1 * x1 + CA) * minv(md(2 * y1)));
        end else begin
            lam = md(md(y2 - y1) * minv(md(x2 - x1)));
        end
        x3 = md(lam * lam - x1 - x2);
        y3 = md(lam * (x1 - x3) - y1);
        return {PW'(x3), PW'(y3)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.eng_out_valid <= 1'b0;
            bus.eng_Rx        <= '0;
            bus.eng_Ry        <= '0;
            pend              <= 1'b0;
            cnt               <= 0;
        end else begin
            bus.eng_out_valid <= 1'b0;
            if (bus.eng_in_valid) begin
                if (eng_calls < 4) begin
                    iss_px[eng_calls]    <= bus.eng_Px;
                    iss_py[eng_calls]    <= bus.eng_Py;
                    iss_qx[eng_calls]    <= bus.eng_Qx;
                    iss_qy[eng_calls]    <= bus.eng_Qy;
                    iss_prime[eng_calls] <= bus.eng_prime;
                    iss_a[eng_calls]     <= bus.eng_a;
                end
                eng_calls <= eng_calls + 1;
                pend <= 1'b1;
                cnt  <= eng_lat;
                h_px <= bus.eng_Px;
                h_py <= bus.eng_Py;
                h_qx <= bus.eng_Qx;
                h_qy <= bus.eng_Qy;
                {res_x, res_y} <= eng_calc(int'(bus.eng_Px), int'(bus.eng_Py),
                                           int'(bus.eng_Qx), int'(bus.eng_Qy), eng_mode);
            end else if (pend) begin
                if ({bus.eng_Px, bus.eng_Py, bus.eng_Qx, bus.eng_Qy} != {h_px, h_py, h_qx, h_qy})
                    op_changes <= op_changes + 1;
                if (cnt <= 1) begin
                    pend <= 1'b0;
                    if (eng_mode != 2) begin
                        bus.eng_out_valid <= 1'b1;
                        bus.eng_Rx        <= res_x;
                        bus.eng_Ry        <= res_y;
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) if (bus.out_valid) ov_count <= ov_count + 1;

    // edges are counted with the in_valid sampling edge as edge 1
    task automatic run_req(input logic [KW-1:0] k, input logic [PW-1:0] px, py, input bit mid_pulse,
                           output int edges, output bit got, output logic [PW-1:0] rx, ry,
                           output logic inf, output int busy_low, output logic err);
        @(negedge clk);
        bus.in_k = k; bus.in_Px = px; bus.in_Py = py;
        bus.in_prime = PW'(PR); bus.in_a = PW'(CA);
        bus.in_valid = 1'b1;
        @(posedge clk);
        edges = 1; got = 1'b0; busy_low = 0;
        rx = '0; ry = '0; inf = 1'b0; err = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (edges < 400 && !got) begin
            @(posedge clk);
            edges++;
            #1;
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                got = 1'b1; rx = bus.out_Rx; ry = bus.out_Ry; inf = bus.out_inf;
`ifdef EC_SM_WDOG_EN
                err = bus.out_err;
`endif
            end else begin
                if (!bus.busy) busy_low++;
                if (mid_pulse && edges == 8) begin
                    bus.in_k = 6'd1; bus.in_Px = 6'd4; bus.in_Py = 6'd0;
                    bus.in_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic check_idle_after(input string tag);
        @(posedge clk); #1;
        n_vec++;
        if ({bus.out_valid, bus.out_inf, bus.out_Rx, bus.out_Ry} !== '0) begin
            n_err++;
            $display("FAIL %s_pulse: out_valid/inf/Rx/Ry=%b/%b/%0d/%0d, required 0/0/0/0",
                     tag, bus.out_valid, bus.out_inf, bus.out_Rx, bus.out_Ry);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.out_valid, bus.out_inf, bus.out_Rx, bus.out_Ry} !== '0) begin
            n_err++;
            $display("FAIL reset_out: busy/ov/inf/Rx/Ry=%b/%b/%b/%0d/%0d, required all 0",
                     bus.busy, bus.out_valid, bus.out_inf, bus.out_Rx, bus.out_Ry);
        end
        n_vec++;
        if ({bus.eng_in_valid, bus.eng_Px, bus.eng_Py, bus.eng_Qx, bus.eng_Qy, bus.eng_prime, bus.eng_a} !== '0) begin
            n_err++;
            $display("FAIL reset_eng: eng_in_valid=%b Px=%0d Py=%0d Qx=%0d Qy=%0d prime=%0d a=%0d, required all 0",
                     bus.eng_in_valid, bus.eng_Px, bus.eng_Py, bus.eng_Qx, bus.eng_Qy, bus.eng_prime, bus.eng_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.out_valid, bus.eng_in_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle: busy/ov/eng_in_valid=%b%b%b, required 000",
                     bus.busy, bus.out_valid, bus.eng_in_valid);
        end
    endtask

    task automatic test_k0;
        int e, bl; bit g; logic [PW-1:0] rx, ry; logic inf, er;
        eng_mode = 0; eng_lat = 1; eng_calls = 0;
        run_req(6'd0, 6'd3, 6'd5, 1'b0, e, g, rx, ry, inf, bl, er);
        n_vec++;
        if (!g || e !== 20) begin
            n_err++; $display("FAIL k0_latency: got=%0d edges=%0d, required got=1 edges=20", g, e);
        end
        n_vec++;
        if ({inf, rx, ry} !== {1'b1, 12'd0}) begin
            n_err++; $display("FAIL k0_result: inf=%b R=(%0d,%0d), required inf=1 R=(0,0)", inf, rx, ry);
        end
        n_vec++;
        if (eng_calls !== 0) begin
            n_err++; $display("FAIL k0_calls: %0d engine requests, required 0", eng_calls);
        end
        n_vec++;
        if (bl !== 0) begin
            n_err++; $display("FAIL k0_busy: busy low for %0d cycles, required 0", bl);
        end
        check_idle_after("k0");
    endtask

    task automatic test_k1;
        int e, bl; bit g; logic [PW-1:0] rx, ry; logic inf, er;
        eng_calls = 0;
        run_req(6'd1, 6'd3, 6'd5, 1'b0, e, g, rx, ry, inf, bl, er);
        n_vec++;
        if (!g || e !== 20) begin
            n_err++; $display("FAIL k1_latency: got=%0d edges=%0d, required got=1 edges=20", g, e);
        end
        n_vec++;
        if ({inf, rx, ry} !== {1'b0, 6'd3, 6'd5}) begin
            n_err++; $display("FAIL k1_result: inf=%b R=(%0d,%0d), required inf=0 R=(3,5)", inf, rx, ry);
        end
        n_vec++;
        if (eng_calls !== 0) begin
            n_err++; $display("FAIL k1_calls: %0d engine requests, required 0", eng_calls);
        end
        check_idle_after("k1");
    endtask

    task automatic test_y_zero;
        int e, bl; bit g; logic [PW-1:0] rx, ry; logic inf, er;
        eng_calls = 0;
        run_req(6'd2, 6'd4, 6'd0, 1'b0, e, g, rx, ry, inf, bl, er);
        n_vec++;
        if (!g || {inf, rx, ry} !== {1'b1, 12'd0}) begin
            n_err++; $display("FAIL y0_result: got=%0d inf=%b R=(%0d,%0d), required inf=1 R=(0,0)", g, inf, rx, ry);
        end
        n_vec++;
        if (eng_calls !== 0) begin
            n_err++; $display("FAIL y0_calls: %0d engine requests, required 0", eng_calls);
        end
    endtask

    task automatic test_k3_engine;
        int e, bl; bit g; logic [PW-1:0] rx, ry; logic inf, er;
        eng_mode = 0; eng_lat = 7; eng_calls = 0; op_changes = 0;
        run_req(6'd3, 6'd3, 6'd5, 1'b0, e, g, rx, ry, inf, bl, er);
        // 2P = (8,3), 3P = 2P + P = (5,9) on y^2 = x^3 + x + 6 mod 11
        n_vec++;
        if (!g || {inf, rx, ry} !== {1'b0, 6'd5, 6'd9}) begin
            n_err++; $display("FAIL k3_result: got=%0d inf=%b R=(%0d,%0d), required inf=0 R=(5,9)", g, inf, rx, ry);
        end
        n_vec++;
        if (eng_calls !== 2) begin
            n_err++; $display("FAIL k3_calls: %0d engine requests, required 2", eng_calls);
        end
        n_vec++;
        if ({iss_px[0], iss_py[0], iss_qx[0], iss_qy[0]} !== {6'd3, 6'd5, 6'd3, 6'd5}) begin
            n_err++; $display("FAIL k3_dbl_ops: (%0d,%0d)+(%0d,%0d), required (3,5)+(3,5)",
                              iss_px[0], iss_py[0], iss_qx[0], iss_qy[0]);
        end
        n_vec++;
        if ({iss_px[1], iss_py[1], iss_qx[1], iss_qy[1]} !== {6'd8, 6'd3, 6'd3, 6'd5}) begin
            n_err++; $display("FAIL k3_add_ops: (%0d,%0d)+(%0d,%0d), required (8,3)+(3,5)",
                              iss_px[1], iss_py[1], iss_qx[1], iss_qy[1]);
        end
        n_vec++;
        if ({iss_prime[0], iss_a[0], iss_prime[1], iss_a[1]} !== {6'd11, 6'd1, 6'd11, 6'd1}) begin
            n_err++; $display("FAIL k3_field: prime/a=%0d/%0d,%0d/%0d, required 11/1,11/1",
                              iss_prime[0], iss_a[0], iss_prime[1], iss_a[1]);
        end
        n_vec++;
        if (op_changes !== 0 || bl !== 0) begin
            n_err++; $display("FAIL k3_hold: operand changes=%0d busy-low cycles=%0d, required 0/0", op_changes, bl);
        end
        n_vec++;
        if ({bus.eng_Px, bus.eng_Py, bus.eng_Qx, bus.eng_Qy} !== '0) begin
            n_err++; $display("FAIL k3_ops_idle: operands (%0d,%0d,%0d,%0d) after completion, required 0",
                              bus.eng_Px, bus.eng_Py, bus.eng_Qx, bus.eng_Qy);
        end
        check_idle_after("k3");
    endtask

    task automatic test_inverse;
        int e, bl, ov0; bit g; logic [PW-1:0] rx, ry; logic inf, er;
        eng_mode = 1; eng_lat = 3; eng_calls = 0;
        ov0 = ov_count;
        run_req(6'd3, 6'd3, 6'd5, 1'b1, e, g, rx, ry, inf, bl, er);
        n_vec++;
        if (!g || {inf, rx, ry} !== {1'b1, 12'd0}) begin
            n_err++; $display("FAIL inv_result: got=%0d inf=%b R=(%0d,%0d), required inf=1 R=(0,0)", g, inf, rx, ry);
        end
        n_vec++;
        if (eng_calls !== 1) begin
            n_err++; $display("FAIL inv_calls: %0d engine requests, required 1", eng_calls);
        end
        repeat (30) @(posedge clk);
        #1;
        n_vec++;
        if (ov_count - ov0 !== 1 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL inv_midpulse: %0d results busy=%b, required 1 result busy=0", ov_count - ov0, bus.busy);
        end
        eng_mode = 0;
    endtask

    task automatic test_reset_mid;
        int e, bl, ov0, w; bit g; logic [PW-1:0] rx, ry; logic inf, er;
        eng_mode = 0; eng_lat = 10; eng_calls = 0;
        @(negedge clk);
        bus.in_k = 6'd3; bus.in_Px = 6'd3; bus.in_Py = 6'd5;
        bus.in_prime = PW'(PR); bus.in_a = PW'(CA); bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.eng_in_valid && w < 40) begin
            @(posedge clk); #1; w++;
        end
        n_vec++;
        if (!bus.eng_in_valid) begin
            n_err++; $display("FAIL rstmid_issue: no engine request within 40 cycles, required one");
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        ov0 = ov_count;
        #1;
        n_vec++;
        if ({bus.busy, bus.out_valid, bus.eng_in_valid, bus.eng_Px, bus.eng_Py, bus.eng_Qx, bus.eng_Qy} !== '0) begin
            n_err++; $display("FAIL rstmid_clear: busy=%b ov=%b eng_Px=%0d eng_Qy=%0d, required all 0",
                              bus.busy, bus.out_valid, bus.eng_Px, bus.eng_Qy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_vec++;
        if (ov_count !== ov0) begin
            n_err++; $display("FAIL rstmid_stale: %0d results after reset, required 0", ov_count - ov0);
        end
        run_req(6'd1, 6'd3, 6'd5, 1'b0, e, g, rx, ry, inf, bl, er);
        n_vec++;
        if (!g || e !== 20 || {inf, rx, ry} !== {1'b0, 6'd3, 6'd5}) begin
            n_err++; $display("FAIL rstmid_next: got=%0d edges=%0d inf=%b R=(%0d,%0d), required edges=20 inf=0 R=(3,5)",
                              g, e, inf, rx, ry);
        end
    endtask

`ifdef EC_SM_WDOG_EN
    task automatic test_wdog;
        int e, bl; bit g; logic [PW-1:0] rx, ry; logic inf, er;
        eng_mode = 2; eng_lat = 1; eng_calls = 0;
        run_req(6'd3, 6'd3, 6'd5, 1'b0, e, g, rx, ry, inf, bl, er);
        n_vec++;
        if (!g || er !== 1'b1) begin
            n_err++; $display("FAIL wdog_err: got=%0d out_err=%b, required got=1 out_err=1", g, er);
        end
        n_vec++;
        if ({inf, rx, ry} !== '0 || eng_calls !== 1) begin
            n_err++; $display("FAIL wdog_out: inf=%b R=(%0d,%0d) calls=%0d, required 0/(0,0)/1", inf, rx, ry, eng_calls);
        end
        eng_mode = 0;
        check_idle_after("wdog");
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0; bus.in_k = '0; bus.in_Px = '0; bus.in_Py = '0;
        bus.in_prime = '0; bus.in_a = '0;
        test_reset;
        test_k0;
        test_k1;
        test_y_zero;
        test_k3_engine;
        test_inverse;
        test_reset_mid;
`ifdef EC_SM_WDOG_EN
        test_wdog;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
